assoc_wb_cache: RTL
===================

// Module: assoc_wb_cache
// PURPOSE
//  N-way set-associative, write-back, write-allocate cache with its own miss FSM.
//  Sits between the core load/store (or fetch) port and the line-wide memory interface.
//  Handles hit/miss detection, victim selection and dirty-line writeback internally.
//  The core only sees a req/ready handshake.
// PARAMETERS
//  WORD_SIZE      32  data word width in bits
//  BYTES_PER_WORD 4   byte lanes per word (WORD_SIZE/8)
//  INDEX_BITS     5   set index width; SETS = 2**INDEX_BITS
//  BLOCK_OFFSET   6   byte-offset width; LINE_BYTES = 2**BLOCK_OFFSET; LINE_BITS = 8*LINE_BYTES
//  WAYS           2   associativity, power of two, 1..8 (WAYS=1 gives direct-mapped)
//  TAG_BITS       32-INDEX_BITS-BLOCK_OFFSET (derived)
// PORTS
//  clk        in   1               rising-edge clock
//  rst        in   1               asynchronous, active-high reset
//  cpu_req    in   1               access request; cpu_* inputs held stable until cpu_ready
//  cpu_we     in   1               1=store, 0=load
//  cpu_addr   in   32              byte address; bits [1:0] ignored
//  cpu_wdata  in   WORD_SIZE       store data
//  cpu_wstrb  in   BYTES_PER_WORD  store byte enables
//  cpu_rdata  out  WORD_SIZE       load data, valid when cpu_ready & ~cpu_we
//  cpu_ready  out  1               access completes this cycle
//  mem_req    out  1               memory transaction request, held until mem_ack
//  mem_we     out  1               1=line writeback, 0=line refill
//  mem_addr   out  32              line-aligned address (low BLOCK_OFFSET bits zero)
//  mem_wline  out  LINE_BITS       victim line data for writeback
//  mem_rline  in   LINE_BITS       refill data, sampled on the mem_ack cycle
//  mem_ack    in   1               single-cycle transaction completion
// BEHAVIOUR
//  Per way/set storage: valid, dirty, tag, line. One round-robin victim pointer per set.
//  Word k of a line occupies bits [k*WORD_SIZE +: WORD_SIZE].
//  Reset (async, any state): all valid/dirty bits = 0, victim pointers = 0, state = IDLE.
//   Outputs held at 0 while rst is high: cpu_ready, cpu_rdata, mem_req, mem_we, mem_addr.
//   An in-flight memory transaction is abandoned; mem_req drops immediately.
//  Hit = any way with valid & tag match. At most one way matches (guaranteed by the fill policy).
//  FSM states: IDLE, WRITEBACK, REFILL.
//  IDLE:
//   - cpu_req & hit: cpu_ready=1 combinationally in the same cycle (0-cycle hit latency).
//     cpu_rdata = selected word.
//     Store: bytes with cpu_wstrb set are written at that clock edge; line dirty <= 1.
//   - cpu_req & miss: choose victim = lowest-index invalid way, else pointer[set].
//     Victim valid & dirty -> WRITEBACK. Otherwise -> REFILL. cpu_ready=0.
//  WRITEBACK: mem_req=1, mem_we=1, mem_addr={victim tag,index,0}, mem_wline=victim line.
//   On mem_ack -> REFILL.
//  REFILL: mem_req=1, mem_we=0, mem_addr={req tag,index,0}.
//   On mem_ack: victim way <= mem_rline, tag <= req tag, valid=1, dirty=0.
//   pointer[set] <= pointer[set]+1, wrapping modulo WAYS. Then -> IDLE.
//  After REFILL, the held request hits in IDLE on the next cycle.
//   Miss latency = writeback + refill handshakes + 1 cycle.
//  mem_ack outside WRITEBACK/REFILL is ignored. The pointer advances only on refill, never on hit.
//  cpu_req deasserted mid-miss: the miss still completes; the line is installed; no cpu_ready pulse.
//  cpu_wstrb = 0 on a store hit: cpu_ready=1, no data change, dirty still set.
//  Memory interface never carries more than one outstanding transaction.
// TESTING
//  1 Reset, load 0x100 (WAYS=2) -> mem_req refill @0x100. Ack with pattern line;
//    next cycle cpu_ready=1 and rdata = word 0.
//  2 Load 0x104 right after test 1 -> cpu_ready=1 in the request cycle, no mem_req.
//  3 Store 0xDEADBEEF, wstrb=4'b0011, to 0x100 -> readback = {orig[31:16],16'hBEEF}; line dirty.
//  4 Same set, loads 0x900 then 0x1100 -> 0x900 fills way1.
//    0x1100 evicts way0 (pointer=0) with writeback @0x100 carrying the test 3 data, then refill @0x1100.
//  5 Assert rst while in REFILL with mem_req high -> mem_req=0 the same cycle.
//    Load 0x100 -> miss (all lines invalid).
//  6 Clean victim eviction -> no mem_we=1 transaction; refill only. Pointer wraps WAYS-1 -> 0.

Source files
------------

// File: rtl/assoc_wb_cache.sv
// N-way set-associative write-back, write-allocate cache with a round-robin victim
// pointer per set; misses run a WRITEBACK/REFILL sequence on a line-wide memory port.
module assoc_wb_cache #(
  parameter int WORD_SIZE      = 32,
  parameter int BYTES_PER_WORD = 4,
  parameter int INDEX_BITS     = 5,
  parameter int BLOCK_OFFSET   = 6,
  parameter int WAYS           = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cpu_req,
  input  logic                              cpu_we,
  input  logic [31:0]                       cpu_addr,
  input  logic [WORD_SIZE-1:0]              cpu_wdata,
  input  logic [BYTES_PER_WORD-1:0]         cpu_wstrb,
  output logic [WORD_SIZE-1:0]              cpu_rdata,
  output logic                              cpu_ready,
  output logic                              mem_req,
  output logic                              mem_we,
  output logic [31:0]                       mem_addr,
  output logic [8*(2**BLOCK_OFFSET)-1:0]    mem_wline,
  input  logic [8*(2**BLOCK_OFFSET)-1:0]    mem_rline,
  input  logic                              mem_ack
);
  localparam int SETS      = 2**INDEX_BITS;
  localparam int LINE_BITS = 8*(2**BLOCK_OFFSET);
  localparam int TAG_BITS  = 32-INDEX_BITS-BLOCK_OFFSET;
  localparam int BYTE_OFF  = $clog2(BYTES_PER_WORD);
  localparam int WSEL_W    = BLOCK_OFFSET-BYTE_OFF;
  localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;
  state_t state, state_next;

  logic [SETS-1:0]      valid [WAYS];
  logic [SETS-1:0]      dirty [WAYS];
  logic [TAG_BITS-1:0]  tag_mem  [WAYS][SETS];
  logic [LINE_BITS-1:0] line_mem [WAYS][SETS];
  logic [WAY_W-1:0]     ptr [SETS];

  logic [TAG_BITS-1:0]   req_tag, miss_tag;
  logic [INDEX_BITS-1:0] req_idx, miss_idx;
  logic [WSEL_W-1:0]     req_word;
  logic [WAY_W-1:0]      hit_way, victim, miss_way;
  logic                  hit, hit_store, miss_start, refill_done;
  logic                  unused_addr;

  assign req_tag     = cpu_addr[31 -: TAG_BITS];
  assign req_idx     = cpu_addr[BLOCK_OFFSET +: INDEX_BITS];
  assign req_word    = cpu_addr[BYTE_OFF +: WSEL_W];
  assign unused_addr = ^cpu_addr[BYTE_OFF-1:0];

  // Lookup; the descending victim scan lets the lowest invalid way win over the pointer.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    victim  = ptr[req_idx];
    for (int w = 0; w < WAYS; w++) begin
      if (valid[w][req_idx] && tag_mem[w][req_idx] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    for (int w = WAYS-1; w >= 0; w--) begin
      if (!valid[w][req_idx]) victim = WAY_W'(w);
    end
  end

  always_comb begin
    state_next  = state;
    cpu_ready   = 1'b0;
    cpu_rdata   = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wline   = line_mem[miss_way][miss_idx];
    hit_store   = 1'b0;
    miss_start  = 1'b0;
    refill_done = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req && hit) begin
          cpu_ready = 1'b1;
          cpu_rdata = line_mem[hit_way][req_idx][int'(req_word)*WORD_SIZE +: WORD_SIZE];
          hit_store = cpu_we;
        end else if (cpu_req) begin
          miss_start = 1'b1;
          state_next = (valid[victim][req_idx] && dirty[victim][req_idx]) ? WRITEBACK : REFILL;
        end
      end
      WRITEBACK: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {tag_mem[miss_way][miss_idx], miss_idx, {BLOCK_OFFSET{1'b0}}};
        if (mem_ack) state_next = REFILL;
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {miss_tag, miss_idx, {BLOCK_OFFSET{1'b0}}};
        if (mem_ack) begin
          refill_done = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // Outputs are forced quiet for the whole reset window, abandoning any transaction.
    if (rst) begin
      cpu_ready = 1'b0;
      cpu_rdata = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      miss_way <= '0;
      miss_tag <= '0;
      miss_idx <= '0;
      for (int w = 0; w < WAYS; w++) begin
        valid[w] <= '0;
        dirty[w] <= '0;
      end
      for (int s = 0; s < SETS; s++) ptr[s] <= '0;
    end else begin
      state <= state_next;
      if (miss_start) begin
        miss_way <= victim;
        miss_tag <= req_tag;
        miss_idx <= req_idx;
      end
      if (hit_store) dirty[hit_way][req_idx] <= 1'b1;
      if (refill_done) begin
        valid[miss_way][miss_idx] <= 1'b1;
        dirty[miss_way][miss_idx] <= 1'b0;
        ptr[miss_idx] <= (ptr[miss_idx] == WAY_W'(WAYS-1)) ? '0 : ptr[miss_idx] + 1'b1;
      end
    end
  end

  // Tag and line storage carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (hit_store) begin
      for (int b = 0; b < BYTES_PER_WORD; b++) begin
        if (cpu_wstrb[b])
          line_mem[hit_way][req_idx][int'(req_word)*WORD_SIZE + b*8 +: 8] <= cpu_wdata[b*8 +: 8];
      end
    end
    if (refill_done) begin
      line_mem[miss_way][miss_idx] <= mem_rline;
      tag_mem[miss_way][miss_idx]  <= miss_tag;
    end
  end
endmodule
